// File: rtl/issue_decode_queue_if.sv
// issue_decode_queue_if: fetch-side push handshake and issue-side decoded head bundle
interface issue_decode_queue_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic [31:0]     in_instr;
  logic            in_ready;
  logic [3:0]      rs_ready;
  logic [3:0]      iss_valid;
  logic [4:0]      iss_rd;
  logic [4:0]      iss_rs1;
  logic [4:0]      iss_rs2;
  logic [XLEN-1:0] iss_imm;
  logic            iss_imminstr;
  logic            iss_isadd;
  logic            iss_ismultiply;
  modport master (
    output in_valid, in_instr, rs_ready,
    input  in_ready, iss_valid, iss_rd, iss_rs1, iss_rs2, iss_imm, iss_imminstr, iss_isadd, iss_ismultiply
  );
  modport slave (
    input  in_valid, in_instr, rs_ready,
    output in_ready, iss_valid, iss_rd, iss_rs1, iss_rs2, iss_imm, iss_imminstr, iss_isadd, iss_ismultiply
  );
endinterface

// File: rtl/issue_decode_queue.sv
// issue_decode_queue: in-order instruction FIFO with combinational head decode and per-class issue.
// Macro ISSUE_DIV_EN enables decoding of DIV into the mult class.
module issue_decode_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  issue_decode_queue_if.slave      q,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   h;
  logic          empty, full, push, pop, drop;
  logic          is_r, is_ld, is_st, is_add, is_sub, is_mul, is_div, is_addi;
  logic [3:0]    cls;
  logic [XLEN-1:0] imm_i, imm_s;
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  assign h     = mem[rd_ptr];
  assign is_r    = h[6:0] == 7'b0110011 && h[14:12] == 3'b000;
  assign is_ld   = h[6:0] == 7'b0000011 && h[14:12] == 3'b010;
  assign is_st   = h[6:0] == 7'b0100011 && h[14:12] == 3'b010;
  assign is_add  = is_r && h[31:25] == 7'b0000000;
  assign is_sub  = is_r && h[31:25] == 7'b0100000;
  assign is_mul  = is_r && h[31:25] == 7'b0000001;
  assign is_addi = h[6:0] == 7'b0010011 && h[14:12] == 3'b000;
`ifdef ISSUE_DIV_EN
  assign is_div  = h[6:0] == 7'b0110011 && h[14:12] == 3'b100 && h[31:25] == 7'b0000001;
`else
  assign is_div  = 1'b0;
`endif
  assign cls   = empty ? 4'b0000 : {is_mul | is_div, is_add | is_sub | is_addi, is_st, is_ld};
  assign imm_i = {{(XLEN-12){h[31]}}, h[31:20]};
  assign imm_s = {{(XLEN-12){h[31]}}, h[31:25], h[11:7]};
  // An illegal head is popped unconditionally so it cannot block the queue
  assign drop = !empty && cls == 4'b0000;
  assign pop  = drop || |(cls & q.rs_ready);
  assign push = q.in_valid && !full;
  always_comb begin
    q.in_ready       = !full;
    q.iss_valid      = cls & q.rs_ready;
    q.iss_rd         = empty ? 5'd0 : h[11:7];
    q.iss_rs1        = empty ? 5'd0 : h[19:15];
    q.iss_rs2        = empty ? 5'd0 : h[24:20];
    q.iss_imm        = empty ? '0 : (is_ld || is_addi) ? imm_i : is_st ? imm_s : '0;
    q.iss_imminstr   = !empty && is_addi;
    q.iss_isadd      = !empty && (is_add || is_addi);
    q.iss_ismultiply = !empty && is_mul;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= q.in_instr;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr + AW'(pop);
      count    <= count + CW'(push) - CW'(pop);
      drop_cnt <= drop_cnt + 8'(drop && drop_cnt != 8'hff);
    end
  end
endmodule

// File: tb/tb_issue_decode_queue.sv
// tb_issue_decode_queue: directed self-checking bench for issue_decode_queue (DEPTH=8, XLEN=32)
module tb_issue_decode_queue;
  logic       clk = 0;
  logic       reset, flush;
  logic [3:0] count;
  logic [7:0] drop_cnt;
  int         passed = 0, total = 0;
  issue_decode_queue_if #(.XLEN(32)) bus ();
  issue_decode_queue #(.DEPTH(8), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .q(bus), .count(count), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else passed++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(logic [31:0] instr);
    bus.in_valid = 1;
    bus.in_instr = instr;
    tick();
    bus.in_valid = 0;
  endtask
  initial begin
    reset = 1; flush = 0;
    bus.in_valid = 1; bus.in_instr = 32'h00500093; bus.rs_ready = 4'b0000;
    tick(); tick();
    reset = 0; bus.in_valid = 0;
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    check("rst_iss_valid", 32'(bus.iss_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_empty_imm", bus.iss_imm, 0);
    check("rst_empty_rd", 32'(bus.iss_rd), 0);
    // ADDI x1,x0,5
    bus.rs_ready = 4'b1111;
    bus.in_valid = 1; bus.in_instr = 32'h00500093;
    #1;
    check("addi_no_bypass", 32'(bus.iss_valid), 0);
    tick();
    bus.in_valid = 0;
    #1;
    check("addi_valid", 32'(bus.iss_valid), 32'b0100);
    check("addi_imm", bus.iss_imm, 5);
    check("addi_imminstr", 32'(bus.iss_imminstr), 1);
    check("addi_isadd", 32'(bus.iss_isadd), 1);
    check("addi_rd", 32'(bus.iss_rd), 1);
    tick();
    check("addi_popped", 32'(count), 0);
    check("addi_after_valid", 32'(bus.iss_valid), 0);
    // SUB x3,x1,x2 then MUL x4,x1,x2 with add RS busy
    bus.rs_ready = 4'b1011;
    push(32'h402081B3);
    push(32'h02208233);
    #1;
    check("stall_valid", 32'(bus.iss_valid), 0);
    check("stall_count", 32'(count), 2);
    check("stall_rd", 32'(bus.iss_rd), 3);
    tick();
    check("stall_hold_count", 32'(count), 2);
    check("stall_hold_rs2", 32'(bus.iss_rs2), 2);
    bus.rs_ready = 4'b1111;
    #1;
    check("sub_valid", 32'(bus.iss_valid), 32'b0100);
    check("sub_isadd", 32'(bus.iss_isadd), 0);
    tick();
    check("mul_valid", 32'(bus.iss_valid), 32'b1000);
    check("mul_ismul", 32'(bus.iss_ismultiply), 1);
    check("mul_rd", 32'(bus.iss_rd), 4);
    tick();
    check("mul_drained", 32'(count), 0);
    // Fill with lw x(i+1), 4*i(x0)
    bus.rs_ready = 4'b0000;
    for (int i = 0; i < 8; i++) push(32'h00002003 | (32'(i * 4) << 20) | (32'(i + 1) << 7));
    check("full_count", 32'(count), 8);
    check("full_in_ready", 32'(bus.in_ready), 0);
    push(32'h00002F83);
    check("full_ignored", 32'(count), 8);
    bus.rs_ready = 4'b0001;
    #1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ld%0d_valid", i), 32'(bus.iss_valid), 32'b0001);
      check($sformatf("ld%0d_rd", i), 32'(bus.iss_rd), i + 1);
      check($sformatf("ld%0d_imm", i), bus.iss_imm, i * 4);
      tick();
    end
    check("ld_drained", 32'(count), 0);
    check("ld_no_extra", 32'(bus.iss_valid), 0);
    // sw x5,-4(x2)
    bus.rs_ready = 4'b0010;
    push(32'hFE512E23);
    #1;
    check("sw_valid", 32'(bus.iss_valid), 32'b0010);
    check("sw_imm", bus.iss_imm, 32'hFFFFFFFC);
    check("sw_rs2", 32'(bus.iss_rs2), 5);
    tick();
    // beq is illegal here
    bus.rs_ready = 4'b1111;
    push(32'h00000063);
    check("beq_valid", 32'(bus.iss_valid), 0);
    check("beq_count", 32'(count), 1);
    tick();
    check("beq_drop", 32'(drop_cnt), 1);
    check("beq_popped", 32'(count), 0);
    // DIV x1,x1,x2
    push(32'h0220C0B3);
`ifdef ISSUE_DIV_EN
    check("div_valid", 32'(bus.iss_valid), 32'b1000);
    check("div_ismul", 32'(bus.iss_ismultiply), 0);
    tick();
    check("div_drop", 32'(drop_cnt), 1);
`else
    check("div_valid", 32'(bus.iss_valid), 0);
    check("div_ismul", 32'(bus.iss_ismultiply), 0);
    tick();
    check("div_drop", 32'(drop_cnt), 2);
`endif
    // Five queued loads, then flush with a concurrent push
    bus.rs_ready = 4'b0000;
    for (int i = 0; i < 5; i++) push(32'h00002083);
    check("pre_flush_count", 32'(count), 5);
    flush = 1; bus.in_valid = 1; bus.in_instr = 32'h00500093;
    tick();
    flush = 0; bus.in_valid = 0; bus.rs_ready = 4'b1111;
    #1;
    check("flush_count", 32'(count), 0);
    check("flush_valid", 32'(bus.iss_valid), 0);
`ifdef ISSUE_DIV_EN
    check("flush_drop_kept", 32'(drop_cnt), 1);
`else
    check("flush_drop_kept", 32'(drop_cnt), 2);
`endif
    // 300 back-to-back illegal pushes: steady push+pop, then saturation
    bus.in_valid = 1; bus.in_instr = 32'h00000000;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 150) check("pushpop_count", 32'(count), 1);
    end
    bus.in_valid = 0;
    tick(); tick();
    check("drop_saturated", 32'(drop_cnt), 255);
    check("drop_drained", 32'(count), 0);
    // Reset while stalled discards queued entries
    bus.rs_ready = 4'b0000;
    push(32'h00002083);
    push(32'h00002083);
    check("prereset_count", 32'(count), 2);
    reset = 1;
    tick();
    reset = 0;
    #1;
    check("midreset_count", 32'(count), 0);
    check("midreset_drop", 32'(drop_cnt), 0);
    check("midreset_in_ready", 32'(bus.in_ready), 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/issue_decode_queue.md
ISSUE_DECODE_QUEUE -- requirements
Module: issue_decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries (power of 2, 2..64).
REQ-002 SHALL have parameter XLEN, default 32, data/immediate width.
REQ-003 SHALL have port clk, input, 1, single clock, rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1, synchronous queue clear.
REQ-006 SHALL have port in_valid, input, 1, fetch offers instruction.
REQ-007 SHALL have port in_instr, input, 32, instruction word.
REQ-008 SHALL have port in_ready, output, 1, queue can accept (= not full).
REQ-009 SHALL have port rs_ready, input, 4, per-class RS free slot [0 load, 1 store, 2 add, 3 mult].
REQ-010 SHALL have port iss_valid, output, 4, one-hot issue strobe per class.
REQ-011 SHALL have ports iss_rd/iss_rs1/iss_rs2, output, 5 each, register fields of head.
REQ-012 SHALL have ports iss_imm, output, XLEN, sign-extended immediate; iss_imminstr, output, 1.
REQ-013 SHALL have ports iss_isadd, output, 1 (0 = SUB); iss_ismultiply, output, 1 (0 = DIV).
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1, occupancy.
REQ-015 SHALL have port drop_cnt, output, 8, saturating count of dropped illegal instructions.

Function
REQ-016 SHALL push in_instr when in_valid and in_ready; no push when full (no same-cycle bypass).
REQ-017 SHALL decode the head entry combinationally; head pushed in cycle N is issuable in N+1 earliest.
REQ-018 SHALL decode: opcode 0000011 funct3 010 -> load, I-imm; 0100011 funct3 010 -> store, S-imm.
REQ-019 SHALL decode 0110011: funct7 0000000/f3 000 ADD (add, isadd=1); 0100000/000 SUB (add, isadd=0); 0000001/000 MUL (mult, ismultiply=1).
REQ-020 SHALL decode 0010011 funct3 000 as ADDI (add, isadd=1, imminstr=1, I-imm); funct7 ignored.
REQ-021 SHALL treat every other encoding as illegal.
REQ-022 SHALL assert iss_valid[c] only when queue non-empty, head is legal class c, and rs_ready[c]=1; pop head the same cycle.
REQ-023 SHALL stall (hold head, iss_valid=0) when rs_ready[c]=0; head fields remain stable.
REQ-024 SHALL pop an illegal head in one cycle with iss_valid=0 and increment drop_cnt, saturating at 255.
REQ-025 SHALL support simultaneous push and pop; count unchanged, pointers wrap modulo DEPTH.
REQ-026 SHALL give flush priority over push/pop: queue empty next cycle, drop_cnt retained, in-flight push discarded.
REQ-027 SHALL drive iss_rd/rs1/rs2/imm/flags to 0 when empty.
REQ-028 SHALL issue strictly in order, at most one instruction per cycle.

Reset
REQ-029 SHALL on reset: pointers 0, count 0, drop_cnt 0, iss_valid 0, in_ready 1; reset has priority over flush.
REQ-030 SHALL ignore in_valid during the reset cycle; reset mid-stall discards all entries.

Configuration
REQ-031 SHALL honour macro ISSUE_DIV_EN: defined -> 0110011 funct7 0000001 funct3 100 decodes as DIV (mult class, ismultiply=0); undefined -> that encoding is illegal (dropped, counted).

Verification
REQ-032 Reset, push ADDI x1,x0,5 (0x00500093), rs_ready=4'b1111 -> next cycle iss_valid=4'b0100, iss_imm=5, imminstr=1, isadd=1, iss_rd=1.
REQ-033 Push SUB then MUL with rs_ready[2]=0 -> head stalls, iss_valid=0, count=2; raise rs_ready[2] -> SUB issues (isadd=0), MUL issues next cycle on class 3.
REQ-034 Fill DEPTH=8 with lw, rs_ready=0 -> count=8, in_ready=0; extra push ignored; enable rs_ready[0] -> 8 loads issue in order over 8 cycles.
REQ-035 Push beq (0x00000063) -> popped with no issue, drop_cnt=1; 300 illegal pushes -> drop_cnt=255.
REQ-036 DIV 0x0220C0B3: with ISSUE_DIV_EN -> iss_valid=4'b1000, ismultiply=0; without -> dropped, drop_cnt+1.
REQ-037 Queue at 5 entries, assert flush with concurrent push -> count=0 next cycle, iss_valid=0, drop_cnt unchanged.
